// File: rtl/fetch_seq.sv
// Instruction-fetch control sequencer: drives PC/MA/MD/IR/C strobes for a single shared bus.
// Optional `SINGLE_STEP_EN adds a step input and a STEP_WAIT state between T2 and EXEC.
module fetch_seq #(
    parameter int MEM_TO = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic             mem_ack,
    input  logic             exec_done,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             PCout,
    output logic             PCin,
    output logic             MAin,
    output logic             INC4,
    output logic             Cin,
    output logic             Cout,
    output logic             mem_rd,
    output logic             MDout,
    output logic             IRin,
    output logic             exec_go,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam int TMO_W = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
`ifdef SINGLE_STEP_EN
        S_STEP_WAIT,
`endif
        S_EXEC1,
        S_EXEC,
        S_HALTED,
        S_ERR
    } state_t;

    state_t           state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             start_q;
    logic             start_rise;
    logic             t1_first;

    assign start_rise = start & ~start_q;
    // The timeout counter is zero exactly in the first T1 cycle.
    assign t1_first   = (tmo_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            start_q   <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= start;
            if (state == S_T0)
                tmo_cnt <= '0;
            else if (state == S_T1 && !mem_ack)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (state == S_T2)
                fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

    // NOTE: every output and next-state is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        PCout     = 1'b0;
        PCin      = 1'b0;
        MAin      = 1'b0;
        INC4      = 1'b0;
        Cin       = 1'b0;
        Cout      = 1'b0;
        mem_rd    = 1'b0;
        MDout     = 1'b0;
        IRin      = 1'b0;
        exec_go   = 1'b0;
        busy      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_T0;
            end
            S_T0: begin
                {PCout, MAin, INC4, Cin, busy} = '1;
                state_nxt = S_T1;
            end
            S_T1: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                Cout   = t1_first;
                PCin   = t1_first;
                if (mem_ack)
                    state_nxt = S_T2;
                else if (tmo_cnt == TMO_W'(MEM_TO - 1))
                    state_nxt = S_ERR;
            end
            S_T2: begin
                {MDout, IRin, busy} = '1;
`ifdef SINGLE_STEP_EN
                state_nxt = S_STEP_WAIT;
`else
                state_nxt = S_EXEC1;
`endif
            end
`ifdef SINGLE_STEP_EN
            S_STEP_WAIT: begin
                busy = 1'b1;
                if (step) state_nxt = S_EXEC1;
            end
`endif
            S_EXEC1, S_EXEC: begin
                busy    = 1'b1;
                exec_go = (state == S_EXEC1);
                if (exec_done)
                    state_nxt = halt ? S_HALTED : S_T0;
                else
                    state_nxt = S_EXEC;
            end
            S_HALTED: begin
                if (start_rise) state_nxt = S_T0;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq; a second instance with CNT_W=2 shares
// all stimulus to exercise fetch_cnt wrap.
module tb_fetch_seq;

    logic clk = 1'b0;
    logic rst, start, halt, mem_ack, exec_done;

    logic        PCout, PCin, MAin, INC4, Cin, Cout, mem_rd, MDout, IRin, exec_go, busy, err;
    logic [15:0] fetch_cnt;
    logic        n_PCout, n_PCin, n_MAin, n_INC4, n_Cin, n_Cout, n_mem_rd, n_MDout, n_IRin;
    logic        n_exec_go, n_busy, n_err;
    logic [1:0]  n_fetch_cnt;

    int n_pass = 0;
    int n_total = 0;

    // Strobe vector order: {PCout,PCin,MAin,INC4,Cin,Cout,mem_rd,MDout,IRin,exec_go,busy,err}
    localparam logic [11:0] S_OFF = 12'b0000_0000_0000;
    localparam logic [11:0] S_T0  = 12'b1011_1000_0010;
    localparam logic [11:0] S_T1F = 12'b0100_0110_0010;
    localparam logic [11:0] S_T1  = 12'b0000_0010_0010;
    localparam logic [11:0] S_T2  = 12'b0000_0001_1010;
    localparam logic [11:0] S_EX1 = 12'b0000_0000_0110;
    localparam logic [11:0] S_EX  = 12'b0000_0000_0010;
    localparam logic [11:0] S_ERR = 12'b0000_0000_0001;

    fetch_seq #(.MEM_TO(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .mem_ack(mem_ack), .exec_done(exec_done),
        .PCout(PCout), .PCin(PCin), .MAin(MAin), .INC4(INC4), .Cin(Cin), .Cout(Cout),
        .mem_rd(mem_rd), .MDout(MDout), .IRin(IRin), .exec_go(exec_go), .busy(busy),
        .err(err), .fetch_cnt(fetch_cnt)
    );

    fetch_seq #(.MEM_TO(16), .CNT_W(2)) dut_narrow (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .mem_ack(mem_ack), .exec_done(exec_done),
        .PCout(n_PCout), .PCin(n_PCin), .MAin(n_MAin), .INC4(n_INC4), .Cin(n_Cin), .Cout(n_Cout),
        .mem_rd(n_mem_rd), .MDout(n_MDout), .IRin(n_IRin), .exec_go(n_exec_go), .busy(n_busy),
        .err(n_err), .fetch_cnt(n_fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [11:0] strobes();
        return {PCout, PCin, MAin, INC4, Cin, Cout, mem_rd, MDout, IRin, exec_go, busy, err};
    endfunction

    function automatic logic [11:0] n_strobes();
        return {n_PCout, n_PCin, n_MAin, n_INC4, n_Cin, n_Cout, n_mem_rd, n_MDout, n_IRin,
                n_exec_go, n_busy, n_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one fetch from the T0 cycle: T1 for dly+1 cycles, then T2 and the first EXEC cycle.
    task automatic run_fetch(input int dly, input int cnt);
        tick();
        check("t1_first", 32'(strobes()), 32'(S_T1F));
        for (int i = 0; i < dly; i++) begin
            tick();
            check("t1_wait", 32'(strobes()), 32'(S_T1));
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t2", 32'(strobes()), 32'(S_T2));
        check("cnt_before_inc", 32'(fetch_cnt), 32'(cnt - 1));
        tick();
        check("exec_go", 32'(strobes()), 32'(S_EX1));
        check("fetch_cnt", 32'(fetch_cnt), 32'(cnt));
        check("fetch_cnt_w2", 32'(n_fetch_cnt), 32'(cnt % 4));
        check("narrow_strobes", 32'(n_strobes()), 32'(S_EX1));
    endtask

    // Bus-ownership invariants checked every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("bus_one_driver", 32'(int'(PCout) + int'(Cout) + int'(MDout) <= 1), 32'd1);
            check("pc_rw_clash", 32'(PCout & PCin), 32'd0);
            check("c_rw_clash", 32'(Cout & Cin), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; start = 1'b0; halt = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
        #3;
        check("reset_strobes", 32'(strobes()), 32'(S_OFF));
        check("reset_cnt", 32'(fetch_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("idle", 32'(strobes()), 32'(S_OFF));

        // Minimum-latency fetch; ack raised in IDLE is ignored.
        mem_ack = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        mem_ack = 1'b0;
        check("t0", 32'(strobes()), 32'(S_T0));
        run_fetch(0, 1);

        // Hold in EXEC, ack outside T1 ignored, then continue.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("exec_wait", 32'(strobes()), 32'(S_EX));
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("t0_again", 32'(strobes()), 32'(S_T0));

        // Ack delayed 5 cycles: six mem_rd cycles, PCin only in the first.
        run_fetch(5, 2);
        check("no_err", 32'(err), 32'd0);

        // exec_done coincident with exec_go.
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("t0_coincident", 32'(strobes()), 32'(S_T0));
        run_fetch(0, 3);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("t0_fetch4", 32'(strobes()), 32'(S_T0));
        run_fetch(1, 4);

        // Halt with start level already high: no restart until a fresh rising edge.
        start = 1'b1;
        halt = 1'b1;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        halt = 1'b0;
        check("halted", 32'(strobes()), 32'(S_OFF));
        check("halted_cnt", 32'(fetch_cnt), 32'd4);
        tick();
        check("halted_level", 32'(strobes()), 32'(S_OFF));
        start = 1'b0;
        tick();
        check("halted_low", 32'(strobes()), 32'(S_OFF));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_t0", 32'(strobes()), 32'(S_T0));
        run_fetch(2, 5);

        // Asynchronous reset in the middle of T1.
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        tick();
        check("pre_reset_t1", 32'(strobes()), 32'(S_T1F));
        #2 rst = 1'b0;
        #1;
        check("async_rst_strobes", 32'(strobes()), 32'(S_OFF));
        check("async_rst_cnt", 32'(fetch_cnt), 32'd0);
        check("async_rst_cnt_w2", 32'(n_fetch_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Memory timeout: 16 T1 cycles without ack, then sticky ERR.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("tmo_t0", 32'(strobes()), 32'(S_T0));
        tick();
        check("tmo_t1_first", 32'(strobes()), 32'(S_T1F));
        for (int i = 1; i < 16; i++) begin
            tick();
            check("tmo_t1", 32'(strobes()), 32'(S_T1));
        end
        tick();
        check("err_state", 32'(strobes()), 32'(S_ERR));
        start = 1'b1;
        mem_ack = 1'b1;
        exec_done = 1'b1;
        repeat (3) tick();
        check("err_sticky", 32'(strobes()), 32'(S_ERR));
        check("err_sticky_w2", 32'(n_strobes()), 32'(S_ERR));
        start = 1'b0;
        mem_ack = 1'b0;
        exec_done = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("err_cleared", 32'(strobes()), 32'(S_OFF));
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("idle_after_err", 32'(strobes()), 32'(S_OFF));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
